key_event_decoder: RTL and testbench

- Downstream stage of the PS/2 frame receiver: consumes its 11-bit frame and prefix/latch strobes (ps2_clk domain) and crosses them into the system clock domain.
- Strips E0/F0 prefixes, checks parity, and tracks modifier/lock state.
- Delivers complete key events through a small FIFO to the CPU-side bus interface with a valid/ready handshake.

---
 rtl/key_event_decoder_pkg.sv | 43 ++++
 rtl/key_event_decoder_sync_fifo.sv | 47 ++++
 rtl/key_event_decoder.sv | 165 ++++++++++++++++
 tb/tb_key_event_decoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_decoder_pkg.sv
// rtl/key_event_decoder_pkg.sv - scancodes, event bit indices and prefix states for the key event decoder
package key_event_decoder_pkg;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam int EV_RELEASE    = 15;
    localparam int EV_EXTENDED   = 14;
    localparam int EV_PARITY_ERR = 13;
    localparam int EV_CAPS       = 12;
    localparam int EV_ALT        = 11;
    localparam int EV_CTRL       = 10;
    localparam int EV_SHIFT      = 9;
    localparam int EV_WIDTH      = 16;

    typedef enum logic [1:0] {
        PFX_IDLE    = 2'b00,
        PFX_EXT     = 2'b01,
        PFX_REL     = 2'b10,
        PFX_EXT_REL = 2'b11
    } pfx_state_t;

    typedef struct packed {
        logic shift_l;
        logic shift_r;
        logic ctrl;
        logic alt;
        logic caps;
    } mod_state_t;

    // Frame data bits arrive d0 first in the shift register, so the byte is bit-reversed.
    function automatic logic [7:0] frame_scancode(input logic [7:0] frame_data);
        logic [7:0] sc;
        for (int i = 0; i < 8; i++) begin
            sc[i] = frame_data[7-i];
        end
        return sc;
    endfunction

endpackage

// File: rtl/key_event_decoder_sync_fifo.sv
// rtl/key_event_decoder_sync_fifo.sv - first-word-fall-through FIFO with wrap-bit pointers
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    // A write into a full FIFO is still taken when the head is popped in the same cycle.
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_en);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance on accepted write/read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - PS/2 byte to key event decoder with CDC, prefix FSM, modifiers and event FIFO
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] rx_frame,
    input  logic        rx_data_latch,
    input  logic        rx_release,
    input  logic        rx_extended,
    input  logic        rx_reset_req,
    output logic [15:0] ev_data,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic        kbd_reset
);

    localparam int STB_EXT   = 0;
    localparam int STB_REL   = 1;
    localparam int STB_LATCH = 2;
    localparam int STB_RST   = 3;

    logic [3:0]                    strobes;
    logic [SYNC_STAGES-1:0][3:0]   sync_q;
    logic [3:0]                    sync_last_q;
    logic [3:0]                    pulse_q;
    logic                          rst_p, latch_p, rel_p, ext_p;

    pfx_state_t                    state_q, state_d;
    logic                          ev_release, ev_extended;

    logic [7:0]                    scancode;
    logic                          parity_err;
    logic                          make;
    mod_state_t                    mod_q, mod_d;
    logic [EV_WIDTH-1:0]           event_d;
    logic                          push_valid_q;
    logic [EV_WIDTH-1:0]           push_data_q;

    logic                          pop;
    logic                          fifo_full, fifo_empty;
    logic [EV_WIDTH-1:0]           fifo_head;
    logic                          drop;
    logic                          unused_frame_bits;

    assign strobes = {rx_reset_req, rx_data_latch, rx_release, rx_extended};
    assign unused_frame_bits = rx_frame[10] ^ rx_frame[0];

    // Synchronize each strobe and register a one-clk rising-edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            sync_last_q <= '0;
            pulse_q     <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], strobes};
            sync_last_q <= sync_q[SYNC_STAGES-1];
            pulse_q     <= sync_q[SYNC_STAGES-1] & ~sync_last_q;
        end
    end

    // Only the highest-priority pulse acts when several land in the same clk.
    assign rst_p   = pulse_q[STB_RST];
    assign latch_p = pulse_q[STB_LATCH] & ~pulse_q[STB_RST];
    assign rel_p   = pulse_q[STB_REL] & ~|pulse_q[STB_RST:STB_LATCH];
    assign ext_p   = pulse_q[STB_EXT] & ~|pulse_q[STB_RST:STB_REL];
    assign kbd_reset = rst_p;

    // Prefix state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= PFX_IDLE;
        else      state_q <= state_d;
    end

    // Prefix next state; an E0 after F0 is ignored.
    always_comb begin
        state_d     = state_q;
        ev_release  = (state_q == PFX_REL) || (state_q == PFX_EXT_REL);
        ev_extended = (state_q == PFX_EXT) || (state_q == PFX_EXT_REL);
        if (rst_p || latch_p) begin
            state_d = PFX_IDLE;
        end else if (rel_p) begin
            case (state_q)
                PFX_IDLE: state_d = PFX_REL;
                PFX_EXT:  state_d = PFX_EXT_REL;
                default:  state_d = state_q;
            endcase
        end else if (ext_p && state_q == PFX_IDLE) begin
            state_d = PFX_EXT;
        end
    end

    // Decode the latched byte, compute post-update modifiers and build the event word.
    always_comb begin
        scancode   = frame_scancode(rx_frame[9:2]);
        parity_err = ~^rx_frame[9:1];
        make       = ~ev_release;
        mod_d      = mod_q;
        if (!parity_err) begin
            case (scancode)
                SC_LSHIFT: mod_d.shift_l = make;
                SC_RSHIFT: mod_d.shift_r = make;
                SC_CTRL:   mod_d.ctrl    = make;
                SC_ALT:    mod_d.alt     = make;
                SC_CAPS:   if (make) mod_d.caps = ~mod_q.caps;
                default:   mod_d = mod_q;
            endcase
        end
        event_d                = '0;
        event_d[EV_RELEASE]    = ev_release;
        event_d[EV_EXTENDED]   = ev_extended;
        event_d[EV_PARITY_ERR] = parity_err;
        event_d[EV_CAPS]       = mod_d.caps;
        event_d[EV_ALT]        = mod_d.alt;
        event_d[EV_CTRL]       = mod_d.ctrl;
        event_d[EV_SHIFT]      = mod_d.shift_l | mod_d.shift_r;
        event_d[7:0]           = scancode;
    end

    // Modifier state and the one-clk-delayed push request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mod_q        <= '0;
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
        end else begin
            push_valid_q <= latch_p;
            push_data_q  <= event_d;
            if (rst_p)        mod_q <= '0;
            else if (latch_p) mod_q <= mod_d;
        end
    end

    assign pop      = ev_valid & ev_ready;
    assign ev_valid = ~fifo_empty;
    assign ev_data  = ev_valid ? fifo_head : '0;
    assign drop     = push_valid_q & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (EV_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (push_valid_q),
        .wr_data (push_data_q),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty)
    );

    // Sticky overflow; a clear wins over a same-cycle drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overflow <= 1'b0;
        else if (ovf_clr) overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - randomized self-checking bench for key_event_decoder
module tb_key_event_decoder;

    localparam int SYNC = 2;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] rx_frame = 11'h001;
    logic        rx_data_latch = 1'b0;
    logic        rx_release = 1'b0;
    logic        rx_extended = 1'b0;
    logic        rx_reset_req = 1'b0;
    logic [15:0] ev_data;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic        kbd_reset;

    int n_tests = 0;
    int n_fail = 0;
    int kbd_total = 0;

    logic [15:0] exp_q[$];
    bit m_rel, m_ext, m_sl, m_sr, m_ctrl, m_alt, m_caps, m_ovf;

    key_event_decoder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .rx_frame(rx_frame), .rx_data_latch(rx_data_latch),
        .rx_release(rx_release), .rx_extended(rx_extended), .rx_reset_req(rx_reset_req),
        .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .overflow(overflow), .ovf_clr(ovf_clr), .kbd_reset(kbd_reset)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (kbd_reset === 1'b1) kbd_total++;

    function automatic logic [10:0] mk_frame(input logic [7:0] sc, input bit bad);
        logic [10:0] f;
        f[10] = 1'b0;
        for (int i = 0; i < 8; i++) f[9-i] = sc[i];
        f[1] = (~^sc) ^ bad;
        f[0] = 1'b1;
        return f;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        {m_rel, m_ext, m_sl, m_sr, m_ctrl, m_alt, m_caps, m_ovf} = '0;
    endtask

    // Reference: keyboard semantics expressed as flags and a bounded queue.
    task automatic model_byte(input logic [7:0] sc, input bit bad);
        logic [15:0] ev;
        bit mk;
        if (sc == 8'hF0) m_rel = 1;
        else if (sc == 8'hE0) begin
            if (!m_rel) m_ext = 1;
        end else if (sc == 8'hAA) begin
            {m_rel, m_ext, m_sl, m_sr, m_ctrl, m_alt, m_caps} = '0;
        end else begin
            mk = !m_rel;
            if (!bad) begin
                if (sc == 8'h12) m_sl = mk;
                if (sc == 8'h59) m_sr = mk;
                if (sc == 8'h14) m_ctrl = mk;
                if (sc == 8'h11) m_alt = mk;
                if (sc == 8'h58 && mk) m_caps = !m_caps;
            end
            ev = 16'(sc) + (m_rel ? 16'h8000 : 16'h0) + (m_ext ? 16'h4000 : 16'h0)
               + (bad ? 16'h2000 : 16'h0) + (m_caps ? 16'h1000 : 16'h0)
               + (m_alt ? 16'h0800 : 16'h0) + (m_ctrl ? 16'h0400 : 16'h0)
               + ((m_sl || m_sr) ? 16'h0200 : 16'h0);
            if (exp_q.size() < DEPTH) exp_q.push_back(ev);
            else m_ovf = 1;
            m_rel = 0;
            m_ext = 0;
        end
    endtask

    task automatic strobe(input int which);
        @(negedge clk);
        #2;
        case (which)
            0: rx_extended = 1'b1;
            1: rx_release = 1'b1;
            2: rx_data_latch = 1'b1;
            default: rx_reset_req = 1'b1;
        endcase
        repeat (4) @(negedge clk);
        {rx_extended, rx_release, rx_data_latch, rx_reset_req} = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] sc, input bit bad);
        model_byte(sc, bad);
        if (sc == 8'hF0) strobe(1);
        else if (sc == 8'hE0) strobe(0);
        else if (sc == 8'hAA) strobe(3);
        else begin
            rx_frame = mk_frame(sc, bad);
            strobe(2);
        end
    endtask

    // Waits (bounded) for a head entry, returns it and pops it.
    task automatic pop_event(output logic [15:0] d, output bit ok);
        int w = 0;
        while (ev_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = (ev_valid === 1'b1);
        d = ev_data;
        if (ok) begin
            ev_ready = 1'b1;
            @(negedge clk);
            ev_ready = 1'b0;
        end
    endtask

    task automatic drain_and_check(input string name);
        logic [15:0] d, e;
        bit ok;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_event(d, ok);
            n_tests++;
            if (!ok || d !== e) begin
                n_fail++;
                $display("FAIL %s event: got %h (valid=%0d) expected %h", name, d, ok, e);
            end
        end
        n_tests++;
        if (ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s empty: ev_valid=%b expected 0", name, ev_valid);
        end
    endtask

    task automatic test_reset();
        n_tests += 4;
        if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset ev_valid: %b expected 0", ev_valid); end
        if (ev_data !== 16'h0) begin n_fail++; $display("FAIL reset ev_data: %h expected 0000", ev_data); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset overflow: %b expected 0", overflow); end
        if (kbd_reset !== 1'b0) begin n_fail++; $display("FAIL reset kbd_reset: %b expected 0", kbd_reset); end
    endtask

    task automatic test_latency();
        int n = 0;
        model_byte(8'h1C, 0);
        rx_frame = mk_frame(8'h1C, 0);
        @(negedge clk);
        rx_data_latch = 1'b1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (ev_valid === 1'b1) break;
        end
        rx_data_latch = 1'b0;
        n_tests++;
        if (n != SYNC + 3) begin
            n_fail++;
            $display("FAIL latency: event visible after %0d clks expected %0d", n, SYNC + 3);
        end
        repeat (4) @(negedge clk);
        drain_and_check("latency");
    endtask

    task automatic test_make_break();
        send_byte(8'h1C, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h1C, 0);
        drain_and_check("make_break");
    endtask

    task automatic test_extended_break();
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h75, 0);
        send_byte(8'h1C, 0);
        drain_and_check("ext_break");
    endtask

    task automatic test_modifiers();
        send_byte(8'h12, 0);
        send_byte(8'h1C, 0);
        send_byte(8'h58, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h12, 0);
        send_byte(8'h1C, 0);
        send_byte(8'hE0, 0);
        send_byte(8'h14, 0);
        send_byte(8'h11, 0);
        send_byte(8'h59, 0);
        drain_and_check("modifiers");
    endtask

    task automatic test_parity();
        send_byte(8'hAA, 0);
        send_byte(8'h1C, 1);
        send_byte(8'h12, 1);
        send_byte(8'h1C, 0);
        send_byte(8'h58, 1);
        send_byte(8'h23, 0);
        drain_and_check("parity");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h20 + 8'(i), 0);
        repeat (4) @(negedge clk);
        n_tests++;
        if (overflow !== m_ovf || m_ovf != 1) begin
            n_fail++;
            $display("FAIL overflow set: overflow=%b expected 1", overflow);
        end
        drain_and_check("overflow");
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        m_ovf = 0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow clear: overflow=%b expected 0", overflow);
        end
    endtask

    task automatic test_bat();
        int k0;
        send_byte(8'h12, 0);
        send_byte(8'h58, 0);
        send_byte(8'hF0, 0);
        k0 = kbd_total;
        send_byte(8'hAA, 0);
        n_tests++;
        if (kbd_total - k0 != 1) begin
            n_fail++;
            $display("FAIL bat pulse: kbd_reset high for %0d clks expected 1", kbd_total - k0);
        end
        send_byte(8'h1C, 0);
        n_tests++;
        if (exp_q.size() != 3 || exp_q[2] != 16'h001C) begin
            n_fail++;
            $display("FAIL bat model: tail %h expected 001c", exp_q[exp_q.size()-1]);
        end
        drain_and_check("bat");
    endtask

    task automatic test_async_reset();
        send_byte(8'h1C, 0);
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        n_tests += 3;
        if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL arst ev_valid: %b expected 0", ev_valid); end
        if (ev_data !== 16'h0) begin n_fail++; $display("FAIL arst ev_data: %h expected 0000", ev_data); end
        if (overflow !== 1'b0 || kbd_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL arst flags: overflow=%b kbd_reset=%b expected 0 0", overflow, kbd_reset);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_byte(8'h1C, 0);
        drain_and_check("arst");
    endtask

    task automatic test_random();
        logic [7:0] picks [8];
        logic [7:0] sc;
        int cnt, r;
        picks = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h1C, 8'h75, 8'h00};
        for (int round = 0; round < 8; round++) begin
            cnt = $urandom_range(1, 7);
            for (int j = 0; j < cnt; j++) begin
                r = $urandom_range(0, 9);
                if (r == 0) send_byte(8'hAA, 0);
                if (r == 1 || r == 2) send_byte(8'hE0, 0);
                if (r >= 2 && r <= 5) send_byte(8'hF0, 0);
                if (r == 6) begin send_byte(8'hF0, 0); send_byte(8'hE0, 0); end
                sc = picks[$urandom_range(0, 7)];
                if (sc == 8'h00) begin
                    sc = 8'($urandom_range(1, 8'h9F));
                end
                send_byte(sc, ($urandom_range(0, 5) == 0));
            end
            drain_and_check("random");
        end
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_latency();
        test_make_break();
        test_extended_break();
        test_modifiers();
        test_parity();
        test_overflow();
        test_bat();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
